// File: rtl/simple_st0_st_act_buf_if.sv
// Bus bundle for simple_st0_st_act_buf: adder result input, activated-value
// output with valid/ready, FIFO occupancy and sticky overflow flag.
// float_24_8 values are carried as 32-bit words: {sgn[31], exp[30:23], man[22:0]}.
interface simple_st0_st_act_buf_if #(
    parameter int AW = 2
) ();
    logic [31:0] simple_st0_st_adder;
    logic        simple_st0_st_adder_valid;
    logic [31:0] act_out;
    logic        act_out_valid;
    logic        act_out_ready;
    logic [AW:0] act_level;
    logic        act_overflow;

    // Producer/consumer side (drives adder results and ready).
    modport master (
        output simple_st0_st_adder, simple_st0_st_adder_valid, act_out_ready,
        input  act_out, act_out_valid, act_level, act_overflow
    );

    // Activation buffer side.
    modport slave (
        input  simple_st0_st_adder, simple_st0_st_adder_valid, act_out_ready,
        output act_out, act_out_valid, act_level, act_overflow
    );
endinterface

// File: rtl/simple_st0_st_act_buf.sv
// Activation buffer: registers ReLU(adder result), then queues it in a
// DEPTH-entry FIFO drained by a valid/ready consumer. Results that arrive
// while the FIFO is full (and not being popped) are dropped and flagged in a
// sticky overflow bit. There is no backpressure toward the adder.
// Build option: define SIMPLE_ST0_ST_ACT_LEAKY_EN for a leaky ReLU (slope 1/8,
// implemented as exponent - 3) instead of plain ReLU.
module simple_st0_st_act_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    simple_st0_st_act_buf_if.slave bus
);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Activation function on a float_24_8 word. exp=0 is a zero/denormal and
    // always maps to +0; non-negative values pass through untouched.
    function automatic logic [31:0] act_fn(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        if (x[30:23] == 8'd0) begin
            y = '0;
        end else if (!x[31]) begin
            y = x;
        end
`ifdef SIMPLE_ST0_ST_ACT_LEAKY_EN
        else if (x[30:23] >= 8'd4) begin
            // Scaling by 1/8 is an exponent decrement of 3; tiny values flush to 0.
            y = {1'b1, x[30:23] - 8'd3, x[22:0]};
        end
`endif
        return y;
    endfunction

    logic              act_v_q, act_v_d;
    logic [31:0]       act_d_q, act_d_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       mem [DEPTH];
    logic              full, pop, push;

    // Stage 1: activation register captures f(adder) whenever a result arrives.
    always_comb begin
        act_v_d = bus.simple_st0_st_adder_valid;
        act_d_d = act_d_q;
        if (bus.simple_st0_st_adder_valid) begin
            act_d_d = act_fn(bus.simple_st0_st_adder);
        end
    end

    // Stage 2: FIFO push/pop decisions, pointer/level update and overflow tracking.
    always_comb begin
        full     = (level_q == LVL_FULL);
        pop      = (level_q != '0) && bus.act_out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push     = act_v_q && (!full || pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
        if (act_v_q && !push) begin
            ovf_d = 1'b1;
        end
    end

    // Control and stage-1 state, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_v_q  <= 1'b0;
            act_d_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            act_v_q  <= act_v_d;
            act_d_q  <= act_d_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are meaningless once the level is cleared, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= act_d_q;
        end
    end

    assign bus.act_out       = mem[rd_ptr_q];
    assign bus.act_out_valid = (level_q != '0);
    assign bus.act_level     = level_q;
    assign bus.act_overflow  = ovf_q;
endmodule
